lfsr_color_gen: RTL and testbench
=================================

LFSR_COLOR_GEN -- requirements
Module: lfsr_color_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per colour channel and LFSR width (WIDTH >= 4).
REQ-002 SHALL have parameter CHANNELS, default 3, number of colour channels packed per output word (>= 1).
REQ-003 SHALL have parameter POLY, default 8'hB8, Galois feedback mask (WIDTH bits).
REQ-004 SHALL have parameter SEED, default 1, LFSR reset value (WIDTH bits; zero is treated as 1).
REQ-005 SHALL have port clk_referencia, input, 1, the single clock (rising edge).
REQ-006 SHALL have port reset, input, 1, synchronous and active-high.
REQ-007 SHALL have port en, input, 1, advance request: one LFSR step per cycle while high.
REQ-008 SHALL have port seed_load, input, 1, load seed_in into the LFSR and restart.
REQ-009 SHALL have port seed_in, input, WIDTH, new seed value.
REQ-010 SHALL have port color_out, output, CHANNELS*WIDTH, registered colour word with channel 0 in the LSBs.
REQ-011 SHALL have port color_valid, output, 1, color_out holds a complete, unconsumed word.
REQ-012 SHALL have port color_ready, input, 1, consumer accepts color_out.

Function
REQ-013 LFSR step SHALL be Galois right-shift: next = (s>>1) ^ (s[0] ? POLY : 0).
REQ-014 LFSR SHALL never hold zero; a computed or loaded zero SHALL be replaced by 1.
REQ-015 FSM SHALL have two states: FILL and HOLD.
REQ-016 In FILL with en=1, each cycle SHALL step the LFSR and write the new value into channel slot cnt, then increment cnt.
REQ-017 In FILL with en=0, the LFSR, cnt and the partial word SHALL hold.
REQ-018 When slot CHANNELS-1 is written, color_out SHALL update with the full word, color_valid SHALL rise on the same edge, cnt SHALL wrap to 0, and the FSM SHALL enter HOLD.
REQ-019 Latency SHALL be CHANNELS en-cycles from FILL entry to color_valid=1.
REQ-020 In HOLD the LFSR SHALL freeze regardless of en, and color_out and color_valid SHALL stay stable until color_ready=1.
REQ-021 In HOLD with color_ready=1, the transfer SHALL complete on that edge: color_valid goes to 0 next cycle and the FSM enters FILL; color_ready is ignored in FILL.
REQ-022 seed_load SHALL have priority over en and ready in any state: LFSR <= seed_in (zero→1), cnt <= 0, partial word discarded, color_valid <= 0, FSM <= FILL.
REQ-023 seed_load together with color_ready in HOLD SHALL count as a restart, not a transfer (the word is dropped).

Reset
REQ-024 With reset=1 on a clock edge: LFSR <= SEED (zero→1), cnt <= 0, FSM <= FILL, color_out <= 0, color_valid <= 0.
REQ-025 reset SHALL override seed_load, en and color_ready, and an in-flight fill or held word SHALL be discarded.
REQ-026 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour is permitted.

Configuration
REQ-027 When macro COLOR_GRAYSCALE_EN is defined, each single LFSR step SHALL fill all CHANNELS slots with the same value, giving latency 1 and skipping cnt.
REQ-028 Without COLOR_GRAYSCALE_EN, the per-channel sequential fill of REQ-016 to REQ-019 SHALL apply.
REQ-029 The handshake, reset and seed behaviour SHALL be identical in both builds.

Verification (WIDTH=8, CHANNELS=3, POLY=8'hB8, SEED=1)
REQ-030 Reset, then en=1 and ready=0 → color_valid rises after 3 cycles with color_out=24'h2E5CB8, and holds for 5 further cycles.
REQ-031 From REQ-030, ready=1 for one cycle with en=1 → valid low for 3 cycles, then color_out=24'hE1B317.
REQ-032 seed_load=1 with seed_in=0 mid-fill (cnt=1) → valid=0 and cnt=0, and the next word equals the REQ-030 word 24'h2E5CB8.
REQ-033 en toggling 1,0,1,0,1 → word completes on the 3rd en-high cycle with the same value as REQ-030, and no step occurs on en=0 cycles.
REQ-034 reset asserted in HOLD with ready=0 → next cycle color_valid=0 and color_out=0, and the sequence restarts from the SEED.
REQ-035 With COLOR_GRAYSCALE_EN: reset then en=1 → first word 24'hB8B8B8 after 1 cycle, second word 24'h5C5C5C after handshake.

Source files
------------

// File: rtl/lfsr_color_gen.sv
// Galois-LFSR colour word generator with a valid/ready output handshake.
// Optional COLOR_GRAYSCALE_EN: one LFSR step fills every channel slot.
module lfsr_color_gen #(
  parameter int              WIDTH    = 8,
  parameter int              CHANNELS = 3,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1)
) (
  input  logic                      clk_referencia,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_in,
  output logic [CHANNELS*WIDTH-1:0] color_out,
  output logic                      color_valid,
  input  logic                      color_ready
);

  localparam int OW = CHANNELS * WIDTH;

  typedef enum logic {FILL, HOLD} state_t;

  function automatic logic [WIDTH-1:0] nz(
    input logic [WIDTH-1:0] v
  );
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] s
  );
    return nz((s >> 1) ^ (s[0] ? POLY : '0));
  endfunction

  localparam logic [WIDTH-1:0] SEED_NZ =
    (SEED == '0) ? WIDTH'(1) : SEED;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] nxt;
  logic [OW-1:0]    out_q, out_d;
  logic             valid_q, valid_d;

`ifndef COLOR_GRAYSCALE_EN
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] word_q, word_d;
`endif

  assign nxt         = step(lfsr_q);
  assign color_out   = out_q;
  assign color_valid = valid_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifndef COLOR_GRAYSCALE_EN
    cnt_d   = cnt_q;
    word_d  = word_q;
`endif
    if (seed_load) begin
      // restart wins over any pending transfer
      lfsr_d  = nz(seed_in);
      valid_d = 1'b0;
      state_d = FILL;
`ifndef COLOR_GRAYSCALE_EN
      cnt_d   = '0;
      word_d  = '0;
`endif
    end else begin
      unique case (state_q)
        FILL: begin
          if (en) begin
            lfsr_d = nxt;
`ifdef COLOR_GRAYSCALE_EN
            out_d   = {CHANNELS{nxt}};
            valid_d = 1'b1;
            state_d = HOLD;
`else
            word_d[int'(cnt_q)*WIDTH +: WIDTH] = nxt;
            if (cnt_q == CW'(CHANNELS - 1)) begin
              out_d   = word_d;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          if (color_ready) begin
            valid_d = 1'b0;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_referencia) begin
    if (reset) begin
      state_q <= FILL;
      lfsr_q  <= SEED_NZ;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifndef COLOR_GRAYSCALE_EN
      cnt_q   <= '0;
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifndef COLOR_GRAYSCALE_EN
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_color_gen.sv
// Bench for lfsr_color_gen: directed known-answer words plus
// randomized traffic against a queue-based reference model.
module tb_lfsr_color_gen;

  logic        clk_referencia = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [7:0]  seed_in = '0;
  logic [23:0] color_out;
  logic        color_valid;
  logic        color_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;

`ifdef COLOR_GRAYSCALE_EN
  localparam int          LAT = 1;
  localparam logic [23:0] W1  = 24'hB8B8B8;
  localparam logic [23:0] W2  = 24'h5C5C5C;
`else
  localparam int          LAT = 3;
  localparam logic [23:0] W1  = 24'h2E5CB8;
  localparam logic [23:0] W2  = 24'hE1B317;
`endif

  lfsr_color_gen dut (
    .clk_referencia(clk_referencia),
    .reset(reset),
    .en(en),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .color_out(color_out),
    .color_valid(color_valid),
    .color_ready(color_ready)
  );

  always #5 clk_referencia = ~clk_referencia;

  // reference model: integer LFSR plus a queue of pending slots
  int          m_lfsr = 1;
  int          m_q[$];
  bit          m_hold = 0;
  logic [23:0] m_out = '0;
  bit          m_valid = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int galois(input int s);
    int n;
    n = (s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
    return (n == 0) ? 1 : n;
  endfunction

  task automatic model(
    input bit r, input bit ld, input int sd,
    input bit e, input bit rdy
  );
    if (r) begin
      m_lfsr = 1; m_q.delete(); m_hold = 0;
      m_out = '0; m_valid = 0;
    end else if (ld) begin
      m_lfsr = (sd == 0) ? 1 : sd;
      m_q.delete(); m_hold = 0; m_valid = 0;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0; m_valid = 0;
      end
    end else if (e) begin
      m_lfsr = galois(m_lfsr);
`ifdef COLOR_GRAYSCALE_EN
      repeat (3) m_q.push_back(m_lfsr);
`else
      m_q.push_back(m_lfsr);
`endif
      if (m_q.size() == 3) begin
        m_out = {m_q[2][7:0], m_q[1][7:0], m_q[0][7:0]};
        m_valid = 1; m_hold = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic cyc(
    input bit r, input bit ld, input logic [7:0] sd,
    input bit e, input bit rdy
  );
    reset = r; seed_load = ld; seed_in = sd;
    en = e; color_ready = rdy;
    @(posedge clk_referencia);
    #1;
    model(r, ld, int'(sd), e, rdy);
    check("valid", 64'(color_valid), 64'(m_valid));
    check("out", 64'(color_out), 64'(m_out));
  endtask

  initial begin
    // reset state
    cyc(1, 0, 0, 0, 0);
    check("rst_valid", 64'(color_valid), 64'd0);
    check("rst_out", 64'(color_out), 64'd0);

    // first word after LAT enabled cycles, then held
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 1, 0);
    check("w1_valid", 64'(color_valid), 64'd1);
    check("w1", 64'(color_out), 64'(W1));
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      check("hold", 64'(color_out), 64'(W1));
    end

    // handshake then second word
    cyc(0, 0, 0, 1, 1);
    check("xfer_valid", 64'(color_valid), 64'd0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 1, 0);
    check("w2", 64'(color_out), 64'(W2));

    // zero seed load mid-fill restarts from 1
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    check("ld_valid", 64'(color_valid), 64'd0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 1, 0);
    check("ld_word", 64'(color_out), 64'(W1));

    // en toggling: no steps on low cycles
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, (i % 2) == 0, 0);
    check("tog_word", 64'(color_out), 64'(W1));

    // reset while holding a word
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 8'h5A, 1, 0);
    check("rh_valid", 64'(color_valid), 64'd0);
    check("rh_out", 64'(color_out), 64'd0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 1, 0);
    check("rh_word", 64'(color_out), 64'(W1));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, ld, e, rdy;
      logic [7:0] sd;
      r   = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      e   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      sd  = ($urandom_range(0, 7) == 0) ? 8'h00
                                        : 8'($urandom);
      cyc(r, ld, sd, e, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
